// File: rtl/complex_mul_pkg.sv
// Shared defaults and helpers for the pipelined complex multiplier.
// Saturation is enabled by defining CMUL_SAT_EN; otherwise results wrap.
package complex_mul_pkg;

    localparam int CMUL_DATA_W  = 16;
    localparam int CMUL_TW_W    = 16;
    localparam int CMUL_FRAC    = 8;
    localparam int CMUL_OUT_W   = 17;
    localparam int CMUL_LATENCY = 3;

    // Half an output LSB, added before the arithmetic shift for round-half-up.
    function automatic logic [63:0] round_const(input int frac);
        return 64'd1 << (frac - 1);
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Round-half-up, scale by 2^-FRAC and narrow one result component.
// With CMUL_SAT_EN the component clamps to the OUT_W range, otherwise it wraps.
module cmul_round_sat
    import complex_mul_pkg::*;
#(
    parameter int IN_W  = CMUL_DATA_W + CMUL_TW_W + 1,
    parameter int FRAC  = CMUL_FRAC,
    parameter int OUT_W = CMUL_OUT_W
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clamped
);

    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] RND = EXT_W'(round_const(FRAC));

    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] scaled;

    // One guard bit keeps the rounding add from overflowing at the extremes.
    assign rounded = EXT_W'(din) + RND;
    assign scaled  = rounded >>> FRAC;

`ifdef CMUL_SAT_EN
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        dout    = scaled[OUT_W-1:0];
        clamped = 1'b0;
        if (scaled > MAX_V) begin
            dout    = MAX_V[OUT_W-1:0];
            clamped = 1'b1;
        end else if (scaled < MIN_V) begin
            dout    = MIN_V[OUT_W-1:0];
            clamped = 1'b1;
        end
    end
`else
    logic unused_hi;

    assign dout      = scaled[OUT_W-1:0];
    assign clamped   = 1'b0;
    assign unused_hi = ^scaled[EXT_W-1:OUT_W];
`endif

endmodule

// File: rtl/complex_mul_pipe.sv
// Three-stage pipelined complex multiplier with a global valid/ready stall.
// Define CMUL_SAT_EN to clamp out-of-range results and report them on sat.
module complex_mul_pipe
    import complex_mul_pkg::*;
#(
    parameter int DATA_W = CMUL_DATA_W,
    parameter int TW_W   = CMUL_TW_W,
    parameter int FRAC   = CMUL_FRAC,
    parameter int OUT_W  = CMUL_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    input  logic                     conj,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_re,
    output logic signed [OUT_W-1:0]  out_im,
    output logic                     sat
);

    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;

    logic advance;

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_re;
    logic signed [DATA_W-1:0] s1_im;
    logic signed [TW_W-1:0]   s1_wre;
    logic signed [TW_W-1:0]   s1_wim;
    logic                     s1_conj;

    logic                 s2_valid;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;
    logic                 s2_conj;

    logic signed [SW-1:0]    sum_re;
    logic signed [SW-1:0]    sum_im;
    logic signed [OUT_W-1:0] rs_re;
    logic signed [OUT_W-1:0] rs_im;
    logic                    cl_re;
    logic                    cl_im;

    // Every stage moves together, so a held output freezes the whole pipe.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_wre   <= '0;
            s1_wim   <= '0;
            s1_conj  <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_re    <= in_re;
            s1_im    <= in_im;
            s1_wre   <= w_re;
            s1_wim   <= w_im;
            s1_conj  <= conj;
        end
    end

    // Products use the raw twiddle; conjugation is folded into the S3 add/sub
    // so negating the most-negative w_im never needs an extra bit here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
            s2_conj  <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            p_rr     <= PW'(s1_re) * PW'(s1_wre);
            p_ii     <= PW'(s1_im) * PW'(s1_wim);
            p_ri     <= PW'(s1_re) * PW'(s1_wim);
            p_ir     <= PW'(s1_im) * PW'(s1_wre);
            s2_conj  <= s1_conj;
        end
    end

    always_comb begin
        if (s2_conj) begin
            sum_re = SW'(p_rr) + SW'(p_ii);
            sum_im = SW'(p_ir) - SW'(p_ri);
        end else begin
            sum_re = SW'(p_rr) - SW'(p_ii);
            sum_im = SW'(p_ri) + SW'(p_ir);
        end
    end

    cmul_round_sat #(
        .IN_W  (SW),
        .FRAC  (FRAC),
        .OUT_W (OUT_W)
    ) u_round_re (
        .din     (sum_re),
        .dout    (rs_re),
        .clamped (cl_re)
    );

    cmul_round_sat #(
        .IN_W  (SW),
        .FRAC  (FRAC),
        .OUT_W (OUT_W)
    ) u_round_im (
        .din     (sum_im),
        .dout    (rs_im),
        .clamped (cl_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            sat       <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_re    <= rs_re;
            out_im    <= rs_im;
            sat       <= cl_re | cl_im;
        end
    end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Self-checking bench for complex_mul_pipe: directed cases, reset flush and a
// randomized valid/ready stream against an integer reference model.
module tb_complex_mul_pipe;

    localparam int DATA_W = 16;
    localparam int TW_W   = 16;
    localparam int FRAC   = 8;
    localparam int OUT_W  = 17;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic signed [TW_W-1:0]   w_re;
    logic signed [TW_W-1:0]   w_im;
    logic                     conj;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_re;
    logic signed [OUT_W-1:0]  out_im;
    logic                     sat;

    typedef struct {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
        logic                    sat;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;

    always #5 clk = ~clk;

    complex_mul_pipe #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W),
        .FRAC   (FRAC),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .conj      (conj),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .sat       (sat)
    );

    // Round half up, shift, then clamp or wrap to the output width.
    function automatic void scaleComp(input longint x, output logic signed [OUT_W-1:0] y,
                                      output logic c);
        longint r;
        r = (x + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        c = 1'b0;
`ifdef CMUL_SAT_EN
        if (r > (longint'(1) <<< (OUT_W - 1)) - 1) begin
            r = (longint'(1) <<< (OUT_W - 1)) - 1;
            c = 1'b1;
        end else if (r < -(longint'(1) <<< (OUT_W - 1))) begin
            r = -(longint'(1) <<< (OUT_W - 1));
            c = 1'b1;
        end
`endif
        y = OUT_W'(r);
    endfunction

    function automatic exp_t refModel(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                                      input logic signed [TW_W-1:0] wr, input logic signed [TW_W-1:0] wi,
                                      input logic cj);
        exp_t   e;
        longint wiEff;
        logic   c1;
        logic   c2;
        wiEff = cj ? -longint'(wi) : longint'(wi);
        scaleComp(longint'(a) * longint'(wr) - longint'(b) * wiEff, e.re, c1);
        scaleComp(longint'(a) * wiEff + longint'(b) * longint'(wr), e.im, c2);
        e.sat = c1 | c2;
        return e;
    endfunction

    function automatic logic [15:0] randVal();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 16'h7FFF;
        if (sel == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] wr, input logic [15:0] wi,
                                 input logic cj, input logic ordy);
        in_valid  = v;
        in_re     = a;
        in_im     = b;
        w_re      = wr;
        w_im      = wi;
        conj      = cj;
        out_ready = ordy;
    endtask

    // Runs at the falling edge: checks the handshake and the head of the
    // expected queue, then books the transfers the next rising edge performs.
    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (in_ready === !(out_valid && !out_ready)) else begin
            errors++;
            $error("[TB] FAIL in_ready observed=%b expected=%b", in_ready, !(out_valid && !out_ready));
        end
        if (out_valid === 1'b1) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("[TB] FAIL spurious_out observed out_valid=1 expected=0");
            end
            if (expq.size() != 0) begin
                e = expq[0];
                checks++;
                assert ({out_re, out_im, sat} === {e.re, e.im, e.sat}) else begin
                    errors++;
                    $error("[TB] FAIL stream_data observed re=%0d im=%0d sat=%b expected re=%0d im=%0d sat=%b",
                           out_re, out_im, sat, e.re, e.im, e.sat);
                end
                if (out_ready === 1'b1) void'(expq.pop_front());
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            expq.push_back(refModel(in_re, in_im, w_re, w_im, conj));
            accepted++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic runSingle(input logic [15:0] a, input logic [15:0] b, input logic [15:0] wr,
                             input logic [15:0] wi, input logic cj, input int expRe, input int expIm,
                             input logic expSat, input string tag);
        int lat;
        applyStimulus(1'b1, a, b, wr, wi, cj, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        assert (lat === 3) else begin
            errors++;
            $error("[TB] FAIL %s_latency observed=%0d expected=3", tag, lat);
        end
        checks++;
        assert ({out_valid, out_re, out_im, sat} === {1'b1, OUT_W'(expRe), OUT_W'(expIm), expSat}) else begin
            errors++;
            $error("[TB] FAIL %s observed v=%b re=%0d im=%0d sat=%b expected v=1 re=%0d im=%0d sat=%b",
                   tag, out_valid, out_re, out_im, sat, expRe, expIm, expSat);
        end
        tick();
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        #12;
        checks++;
        assert ({out_valid, out_re, out_im, sat, in_ready} === {1'b0, {OUT_W{1'b0}}, {OUT_W{1'b0}}, 1'b0, 1'b1}) else begin
            errors++;
            $error("[TB] FAIL reset_state observed v=%b re=%0d im=%0d sat=%b rdy=%b expected v=0 re=0 im=0 sat=0 rdy=1",
                   out_valid, out_re, out_im, sat, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        $display("[TB] directed cases");
        runSingle(16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 256, 0, 1'b0, "unity");
        runSingle(16'h0100, 16'h0100, 16'h0000, 16'h0100, 1'b0, -256, 256, 1'b0, "rot_plain");
        runSingle(16'h0100, 16'h0100, 16'h0000, 16'h0100, 1'b1, 256, -256, 1'b0, "rot_conj");
        runSingle(16'h0080, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1, 0, 1'b0, "round_pos_half");
        runSingle(16'hFF7F, 16'h0000, 16'h0001, 16'h0000, 1'b0, -1, 0, 1'b0, "round_neg");
`ifdef CMUL_SAT_EN
        runSingle(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 65535, -128, 1'b1, "sat_extreme");
`else
        runSingle(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, -384, -128, 1'b0, "wrap_extreme");
`endif

        $display("[TB] reset with samples in flight");
        applyStimulus(1'b1, 16'h0010, 16'h0020, 16'h0100, 16'h0000, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0030, 16'h0040, 16'h0100, 16'h0000, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0050, 16'h0060, 16'h0100, 16'h0000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        assert ({out_valid, out_re, out_im, sat, in_ready} === {1'b0, {OUT_W{1'b0}}, {OUT_W{1'b0}}, 1'b0, 1'b1}) else begin
            errors++;
            $error("[TB] FAIL reset_flush observed v=%b re=%0d im=%0d sat=%b rdy=%b expected v=0 re=0 im=0 sat=0 rdy=1",
                   out_valid, out_re, out_im, sat, in_ready);
        end
        expq.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        runSingle(16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 256, 0, 1'b0, "after_reset");

        $display("[TB] random stream");
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            applyStimulus($urandom_range(0, 3) != 0, randVal(), randVal(), randVal(), randVal(),
                          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
            tick();
            cyc++;
        end
        checks++;
        assert (accepted === 1000) else begin
            errors++;
            $error("[TB] FAIL stream_accept observed=%0d expected=1000", accepted);
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        cyc = 0;
        while (expq.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        assert (expq.size() === 0) else begin
            errors++;
            $error("[TB] FAIL stream_drain observed pending=%0d expected=0", expq.size());
        end
        for (int i = 0; i < 4; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_mul_pipe.md
COMPLEX_MUL_PIPE -- requirements
Module: complex_mul_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: signed sample component width.
REQ-002 The block SHALL have parameter TW_W, default 16: signed twiddle component width.
REQ-003 The block SHALL have parameter FRAC, default 8: right-shift applied to full-precision result (FRAC >= 1).
REQ-004 The block SHALL have parameter OUT_W, default 17: signed output component width.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-009 The block SHALL have ports in_re and in_im, input, DATA_W bits: sample real/imag, two's complement.
REQ-010 The block SHALL have ports w_re and w_im, input, TW_W bits: twiddle real/imag, two's complement.
REQ-011 The block SHALL have port conj, input, 1 bit: sampled with input; 1 = multiply by conjugate twiddle.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-014 The block SHALL have ports out_re and out_im, output, OUT_W bits: result real/imag.
REQ-015 The block SHALL have port sat, output, 1 bit: result clamped; qualified by out_valid.

Function
REQ-016 Arithmetic SHALL be fully signed; with wi = conj ? -w_im : w_im: re = in_re*w_re - in_im*wi, im = in_re*wi + in_im*w_re.
REQ-017 Internal sums SHALL be DATA_W+TW_W+1 bits wide, so no overflow occurs before output scaling (includes negating most-negative w_im).
REQ-018 Scaling SHALL be round-half-up: add 2^(FRAC-1), then arithmetic shift right by FRAC.
REQ-019 Pipeline SHALL have 3 register stages: S1 input capture, S2 four products, S3 add/sub plus round/scale; latency 3 cycles with no stall.
REQ-020 Each stage SHALL carry a valid bit; a transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
REQ-021 Stall SHALL be global: advance = !out_valid || out_ready; in_ready = advance; no stage updates when advance is 0.
REQ-022 Throughput SHALL be one result per cycle while out_ready is held at 1.
REQ-023 out_re, out_im and sat SHALL hold stable while out_valid && !out_ready.
REQ-024 Bubbles (in_valid=0 while advancing) SHALL propagate as cleared valid bits; data registers of invalid stages are don't-care.
REQ-025 Results SHALL emerge in input order; no sample SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-026 Asserting rst SHALL immediately clear all stage valid bits, out_valid, sat, out_re and out_im to 0; in_ready reads 1 during and after reset.
REQ-027 Reset mid-operation SHALL discard all in-flight samples; the first accepted input after release yields the first output.

Configuration
REQ-028 With CMUL_SAT_EN defined, each scaled component exceeding the OUT_W signed range SHALL clamp to the max/min value, and sat=1 if either component clamped.
REQ-029 Without CMUL_SAT_EN, scaled components SHALL wrap (low OUT_W bits kept) and sat SHALL be tied to 0.

Structure
REQ-030 Package complex_mul_pkg SHALL hold default widths, the pipeline latency constant (3), and the rounding-constant helper.
REQ-031 Sub-module cmul_round_sat (round, shift, optional saturate, one component) SHALL be instantiated twice in S3.

Verification
REQ-032 Defaults, in_re=0x0100, in_im=0, w_re=0x0100, w_im=0, conj=0 -> 3 cycles later out_re=256, out_im=0, sat=0.
REQ-033 in_re=in_im=0x0100, w_re=0, w_im=0x0100: conj=0 -> (-256, +256); conj=1 -> (+256, -256).
REQ-034 With CMUL_SAT_EN, in_re=0x7FFF, in_im=0x8000, w_re=w_im=0x7FFF -> out_re=65535, out_im=-128, sat=1; without the macro, sat=0 and out_re equals the low 17 bits of the wrapped value.
REQ-035 Random stream of 1000 samples with random out_ready and in_valid -> outputs match the reference model in order with no loss; in_ready=0 exactly when out_valid && !out_ready.
REQ-036 Assert rst with 3 samples in flight -> out_valid drops that cycle; no stale result appears after release.
REQ-037 Rounding case: product sum = 0x80 with FRAC=8 -> result 1; sum = -0x81 -> result -1.
